// File: rtl/cluster_seq_pkg.sv
// Shared definitions for the cluster power sequencer.
//   seq_state_e   : sequencer FSM states
//   PWR_STATE_*   : encodings driven on pwr_state_o
//   DRAIN_TIMEOUT : busy cycles tolerated in DRAIN before the forced shutdown
//                   (only used when CLUSTER_SEQ_TIMEOUT_EN is defined)
//   state_ctrl()  : cluster control pins {pow, clk_en, rstn, fetch} per state
//   state_code()  : pwr_state_o encoding per state
package cluster_seq_pkg;

    typedef enum logic [3:0] {
        ST_OFF      = 4'd0,
        ST_PWR_UP   = 4'd1,
        ST_CLK_UP   = 4'd2,
        ST_RST_REL  = 4'd3,
        ST_RUN      = 4'd4,
        ST_DRAIN    = 4'd5,
        ST_RST_ASRT = 4'd6,
        ST_CLK_DN   = 4'd7,
        ST_PWR_DN   = 4'd8
    } seq_state_e;

    localparam logic [1:0] PWR_STATE_OFF     = 2'b00;
    localparam logic [1:0] PWR_STATE_TRANS   = 2'b01;
    localparam logic [1:0] PWR_STATE_RUN     = 2'b10;
    localparam logic [1:0] PWR_STATE_TIMEOUT = 2'b11;

    localparam int unsigned DRAIN_TIMEOUT = 32'd1024;
    localparam int unsigned DRAIN_CNT_W   = $clog2(DRAIN_TIMEOUT);

    typedef struct packed {
        logic pow;
        logic clk_en;
        logic rstn;
        logic fetch;
    } seq_ctrl_t;

    function automatic seq_ctrl_t state_ctrl(input seq_state_e st);
        seq_ctrl_t ctrl;
        case (st)
            ST_OFF:      ctrl = seq_ctrl_t'(4'b0000);
            ST_PWR_UP:   ctrl = seq_ctrl_t'(4'b1000);
            ST_CLK_UP:   ctrl = seq_ctrl_t'(4'b1100);
            ST_RST_REL:  ctrl = seq_ctrl_t'(4'b1110);
            ST_RUN:      ctrl = seq_ctrl_t'(4'b1111);
            ST_DRAIN:    ctrl = seq_ctrl_t'(4'b1110);
            ST_RST_ASRT: ctrl = seq_ctrl_t'(4'b1100);
            ST_CLK_DN:   ctrl = seq_ctrl_t'(4'b1000);
            ST_PWR_DN:   ctrl = seq_ctrl_t'(4'b0000);
            default:     ctrl = seq_ctrl_t'(4'b0000);
        endcase
        return ctrl;
    endfunction

    // A sticky timeout error overrides the normal state reporting.
    function automatic logic [1:0] state_code(input seq_state_e st, input logic timeout_err);
        logic [1:0] code;
        if (timeout_err) begin
            code = PWR_STATE_TIMEOUT;
        end else begin
            case (st)
                ST_OFF:  code = PWR_STATE_OFF;
                ST_RUN:  code = PWR_STATE_RUN;
                default: code = PWR_STATE_TRANS;
            endcase
        end
        return code;
    endfunction

endpackage

// File: rtl/cluster_seq_timer.sv
// Down-counter used for the settle/reset dwell times of the sequencer.
//   clk_i     : clock
//   rst_i     : synchronous active-high reset (counter cleared to 0)
//   load_i    : load value_i into the counter this cycle
//   value_i   : dwell length N in cycles
//   expired_o : high on the last cycle of the dwell; a load of N gives
//               max(N,1) cycles of dwell because 0 and 1 both read as expired
module cluster_seq_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] value_i,
    output logic             expired_o
);

    logic [WIDTH-1:0] count_r;

    // Countdown register, saturating at zero
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_r <= {WIDTH{1'b0}};
        end else if (load_i) begin
            count_r <= value_i;
        end else if (count_r != {WIDTH{1'b0}}) begin
            count_r <= count_r - WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired_o = (count_r <= WIDTH'(1));

endmodule

// File: rtl/cluster_pwr_sequencer.sv
// Cluster power sequencer: brings a cluster up (power, clock, reset release,
// fetch enable) and down (drain, reset, clock stop, power off) in order.
// All outputs are registered and follow the FSM state one cycle behind.
// Optional build macro: CLUSTER_SEQ_TIMEOUT_EN adds a DRAIN timeout that forces
// shutdown after DRAIN_TIMEOUT busy cycles and reports pwr_state_o = 2'b11.
// Ports:
//   clk_i, rst_i              : clock, synchronous active-high reset
//   pwr_req_i                 : level request (1 = on), sampled in OFF and RUN
//   boot_addr_i               : boot address, latched when power-up starts
//   pwr_dly_i, rst_dly_i      : settle cycles after power switch / reset hold
//   cluster_busy_i            : cluster still active, holds DRAIN
//   cluster_pow_o/clk_en_o/rstn_o/fetch_enable_o : cluster controls
//   cluster_boot_addr_o       : latched boot address
//   pwr_state_o               : 00 off, 01 transitioning, 10 running, 11 timeout
//   evt_o                     : one-cycle pulse on reaching RUN or OFF
module cluster_pwr_sequencer
    import cluster_seq_pkg::*;
#(
    parameter int unsigned BOOT_ADDR_WIDTH = 64,
    parameter int unsigned DLY_WIDTH       = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       pwr_req_i,
    input  logic [BOOT_ADDR_WIDTH-1:0] boot_addr_i,
    input  logic [DLY_WIDTH-1:0]       pwr_dly_i,
    input  logic [DLY_WIDTH-1:0]       rst_dly_i,
    input  logic                       cluster_busy_i,
    output logic                       cluster_pow_o,
    output logic                       cluster_clk_en_o,
    output logic                       cluster_rstn_o,
    output logic                       cluster_fetch_enable_o,
    output logic [BOOT_ADDR_WIDTH-1:0] cluster_boot_addr_o,
    output logic [1:0]                 pwr_state_o,
    output logic                       evt_o
);

    seq_state_e           state_r;
    seq_state_e           state_n;
    logic                 tmr_load_s;
    logic [DLY_WIDTH-1:0] tmr_val_s;
    logic                 tmr_expired_s;
    logic                 boot_latch_s;
    logic                 timeout_hit_s;
    logic                 timeout_err_s;
    logic                 enter_evt_r;
    seq_ctrl_t            ctrl_s;

    cluster_seq_timer #(
        .WIDTH(DLY_WIDTH)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (tmr_load_s),
        .value_i   (tmr_val_s),
        .expired_o (tmr_expired_s)
    );

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_OFF;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state logic and dwell-timer loads
    always_comb begin
        state_n      = state_r;
        tmr_load_s   = 1'b0;
        tmr_val_s    = pwr_dly_i;
        boot_latch_s = 1'b0;
        case (state_r)
            ST_OFF: begin
                if (pwr_req_i) begin
                    state_n      = ST_PWR_UP;
                    tmr_load_s   = 1'b1;
                    tmr_val_s    = pwr_dly_i;
                    boot_latch_s = 1'b1;
                end else begin
                    state_n = ST_OFF;
                end
            end
            ST_PWR_UP: begin
                if (tmr_expired_s) begin
                    state_n    = ST_CLK_UP;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = rst_dly_i;
                end else begin
                    state_n = ST_PWR_UP;
                end
            end
            ST_CLK_UP: begin
                if (tmr_expired_s) begin
                    state_n = ST_RST_REL;
                end else begin
                    state_n = ST_CLK_UP;
                end
            end
            ST_RST_REL: state_n = ST_RUN;
            ST_RUN: begin
                if (!pwr_req_i) begin
                    state_n = ST_DRAIN;
                end else begin
                    state_n = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // Idle cluster and timeout both lead into the reset phase.
                if (!cluster_busy_i || timeout_hit_s) begin
                    state_n    = ST_RST_ASRT;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = rst_dly_i;
                end else begin
                    state_n = ST_DRAIN;
                end
            end
            ST_RST_ASRT: begin
                if (tmr_expired_s) begin
                    state_n = ST_CLK_DN;
                end else begin
                    state_n = ST_RST_ASRT;
                end
            end
            ST_CLK_DN: begin
                state_n    = ST_PWR_DN;
                tmr_load_s = 1'b1;
                tmr_val_s  = pwr_dly_i;
            end
            ST_PWR_DN: begin
                if (tmr_expired_s) begin
                    state_n = ST_OFF;
                end else begin
                    state_n = ST_PWR_DN;
                end
            end
            default: state_n = ST_OFF;
        endcase
    end

`ifdef CLUSTER_SEQ_TIMEOUT_EN
    logic [DRAIN_CNT_W-1:0] drain_cnt_r;
    logic                   err_r;

    // Busy cycles spent in DRAIN; restarts from zero on every DRAIN entry
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drain_cnt_r <= {DRAIN_CNT_W{1'b0}};
        end else if (state_r != ST_DRAIN) begin
            drain_cnt_r <= {DRAIN_CNT_W{1'b0}};
        end else if (drain_cnt_r != {DRAIN_CNT_W{1'b1}}) begin
            drain_cnt_r <= drain_cnt_r + DRAIN_CNT_W'(1);
        end else begin
            drain_cnt_r <= drain_cnt_r;
        end
    end

    assign timeout_hit_s = (state_r == ST_DRAIN) &&
                           (drain_cnt_r == DRAIN_CNT_W'(DRAIN_TIMEOUT - 32'd1));

    // Sticky timeout error, cleared only when a new power-up starts
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_r <= 1'b0;
        end else if (boot_latch_s) begin
            err_r <= 1'b0;
        end else if ((state_r == ST_DRAIN) && cluster_busy_i && timeout_hit_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign timeout_err_s = err_r;
`else
    assign timeout_hit_s = 1'b0;
    assign timeout_err_s = 1'b0;
`endif

    assign ctrl_s = state_ctrl(state_r);

    // Registered outputs decoded from the current state; the boot address is
    // captured on the same edge that leaves OFF
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cluster_pow_o          <= 1'b0;
            cluster_clk_en_o       <= 1'b0;
            cluster_rstn_o         <= 1'b0;
            cluster_fetch_enable_o <= 1'b0;
            cluster_boot_addr_o    <= {BOOT_ADDR_WIDTH{1'b0}};
            pwr_state_o            <= PWR_STATE_OFF;
            enter_evt_r            <= 1'b0;
            evt_o                  <= 1'b0;
        end else begin
            cluster_pow_o          <= ctrl_s.pow;
            cluster_clk_en_o       <= ctrl_s.clk_en;
            cluster_rstn_o         <= ctrl_s.rstn;
            cluster_fetch_enable_o <= ctrl_s.fetch;
            pwr_state_o            <= state_code(state_r, timeout_err_s);
            // Entry flag is delayed once more so the pulse lines up with the
            // state-decoded outputs.
            enter_evt_r <= (state_n != state_r) && ((state_n == ST_RUN) || (state_n == ST_OFF));
            evt_o       <= enter_evt_r;
            if (boot_latch_s) begin
                cluster_boot_addr_o <= boot_addr_i;
            end else begin
                cluster_boot_addr_o <= cluster_boot_addr_o;
            end
        end
    end

endmodule

// File: tb/tb_cluster_pwr_sequencer.sv
// Self-checking bench for cluster_pwr_sequencer. A timeline model predicts
// every output from the sequencing rules (dwell lengths, lag of the registered
// outputs) and is compared on every falling edge; directed scenarios add
// hand-computed latency/ordering checks.
module tb_cluster_pwr_sequencer;

`ifdef CLUSTER_SEQ_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    localparam int PH_OFF   = 0;
    localparam int PH_UP    = 1;
    localparam int PH_DRAIN = 2;
    localparam int PH_DOWN  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        pwr_req;
    logic [63:0] boot_addr;
    logic [7:0]  pwr_dly;
    logic [7:0]  rst_dly;
    logic        busy;
    logic        pow, clk_en, rstn, fetch, evt;
    logic [63:0] boot_out;
    logic [1:0]  pst;

    int n_checks = 0;
    int n_err    = 0;
    int evt_seen = 0;
    bit chk_en   = 1'b0;

    cluster_pwr_sequencer dut (
        .clk_i                  (clk),
        .rst_i                  (rst),
        .pwr_req_i              (pwr_req),
        .boot_addr_i            (boot_addr),
        .pwr_dly_i              (pwr_dly),
        .rst_dly_i              (rst_dly),
        .cluster_busy_i         (busy),
        .cluster_pow_o          (pow),
        .cluster_clk_en_o       (clk_en),
        .cluster_rstn_o         (rstn),
        .cluster_fetch_enable_o (fetch),
        .cluster_boot_addr_o    (boot_out),
        .pwr_state_o            (pst),
        .evt_o                  (evt)
    );

    always #5 clk = ~clk;

    // Model: phase plus the edge index where the phase began (anchor); the
    // expected outputs after edge n follow from k = n - anchor.
    typedef struct packed {
        int          phase;
        int          anchor;
        int          dp;
        int          dr;
        int          cyc;
        logic [63:0] boot;
        logic        err;
        logic [3:0]  e_ctrl;
        logic [1:0]  e_pst;
        logic        e_evt;
        logic [63:0] e_boot;
    } mdl_t;

    mdl_t m;

    function automatic int max1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    function automatic mdl_t step(input mdl_t cur, input logic r, input logic req,
                                  input logic bsy, input logic [63:0] addr,
                                  input int pd, input int rd);
        mdl_t       nx;
        int         k;
        logic [3:0] o;
        int         base;
        logic       ev;
        logic       may_start;
        nx = cur;
        nx.cyc = cur.cyc + 1;
        k = nx.cyc - cur.anchor;
        o = 4'b0000;
        base = 0;
        ev = 1'b0;
        may_start = 1'b0;
        if (r) begin
            nx.phase  = PH_OFF;
            nx.err    = 1'b0;
            nx.boot   = 64'd0;
            nx.e_ctrl = 4'b0000;
            nx.e_pst  = 2'b00;
            nx.e_evt  = 1'b0;
            nx.e_boot = 64'd0;
            return nx;
        end
        case (cur.phase)
            PH_OFF: may_start = 1'b1;
            PH_UP: begin
                if (k <= cur.dp) begin
                    o = 4'b1000; base = 1;
                end else if (k <= cur.dp + cur.dr) begin
                    o = 4'b1100; base = 1;
                end else if (k == cur.dp + cur.dr + 1) begin
                    o = 4'b1110; base = 1;
                end else begin
                    o = 4'b1111; base = 2;
                    ev = (k == cur.dp + cur.dr + 2);
                    if (!req) begin
                        nx.phase = PH_DRAIN; nx.anchor = nx.cyc;
                    end
                end
            end
            PH_DRAIN: begin
                o = 4'b1110; base = 1;
                if (!bsy) begin
                    nx.phase = PH_DOWN; nx.anchor = nx.cyc;
                    nx.dp = max1(pd); nx.dr = max1(rd);
                end else if (TIMEOUT_ON && k == 1024) begin
                    nx.phase = PH_DOWN; nx.anchor = nx.cyc;
                    nx.dp = max1(pd); nx.dr = max1(rd);
                    nx.err = 1'b1;
                end
            end
            default: begin
                if (k <= cur.dr) begin
                    o = 4'b1100; base = 1;
                end else if (k == cur.dr + 1) begin
                    o = 4'b1000; base = 1;
                end else if (k <= cur.dr + cur.dp + 1) begin
                    o = 4'b0000; base = 1;
                end else begin
                    ev = 1'b1; nx.phase = PH_OFF; may_start = 1'b1;
                end
            end
        endcase
        if (may_start && req) begin
            nx.phase = PH_UP; nx.anchor = nx.cyc;
            nx.dp = max1(pd); nx.dr = max1(rd);
            nx.boot = addr; nx.err = 1'b0;
        end
        nx.e_ctrl = o;
        nx.e_pst  = cur.err ? 2'b11 : 2'(base);
        nx.e_evt  = ev;
        nx.e_boot = nx.boot;
        return nx;
    endfunction

    always @(posedge clk) begin
        m <= step(m, rst, pwr_req, busy, boot_addr, int'(pwr_dly), int'(rst_dly));
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("pow",        64'(pow),    64'(m.e_ctrl[3]));
            check("clk_en",     64'(clk_en), 64'(m.e_ctrl[2]));
            check("rstn",       64'(rstn),   64'(m.e_ctrl[1]));
            check("fetch",      64'(fetch),  64'(m.e_ctrl[0]));
            check("pwr_state",  64'(pst),    64'(m.e_pst));
            check("evt",        64'(evt),    64'(m.e_evt));
            check("boot_addr",  boot_out,    m.e_boot);
        end
        if (evt === 1'b1) evt_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edges after the sample edge until fetch rises
    task automatic wait_fetch(input string name, output int lat);
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            lat++;
            if (fetch === 1'b1) break;
        end
        check({name, " fetch reached"}, 64'(fetch), 64'd1);
    endtask

    task automatic wait_off(input string name);
        for (int i = 0; i < 100; i++) begin
            tick();
            if (evt === 1'b1 && pow === 1'b0) break;
        end
        check({name, " off reached"}, 64'({evt, pow}), 64'(2'b10));
    endtask

    int lat;
    int e0;
    int t_rstn, t_clk, t_pow, t_evt;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; pwr_req = 1'b0; busy = 1'b0;
        boot_addr = 64'd0; pwr_dly = 8'd4; rst_dly = 8'd3;
        tick();
        chk_en = 1'b1;
        tick(); tick();
        check("reset ctrl", 64'({pow, clk_en, rstn, fetch, evt}), 64'd0);
        check("reset pwr_state", 64'(pst), 64'd0);
        rst = 1'b0;
        tick(); tick();

        // Power-up 4/3: fetch 9 edges after the sample edge
        boot_addr = 64'h1C00_8080; pwr_req = 1'b1;
        e0 = evt_seen;
        tick();
        boot_addr = 64'hDEAD_BEEF;
        wait_fetch("pwr_up", lat);
        check("pwr_up latency", 64'(lat), 64'd9);
        check("pwr_up boot_addr", boot_out, 64'h1C00_8080);
        tick(); tick(); tick();
        check("pwr_up evt count", 64'(evt_seen - e0), 64'd1);
        check("run pwr_state", 64'(pst), 64'(2'b10));

        // Power-down with busy held for 10 cycles
        busy = 1'b1; pwr_req = 1'b0;
        tick();
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            lat++;
            if (fetch === 1'b0) break;
        end
        check("drain fetch drop", 64'(lat), 64'd1);
        repeat (8) tick();
        check("drain holds rstn/clk/pow", 64'({pow, clk_en, rstn}), 64'(3'b111));
        busy = 1'b0;
        tick();
        t_rstn = -1; t_clk = -1; t_pow = -1; t_evt = -1;
        for (int j = 1; j <= 20; j++) begin
            tick();
            if (rstn === 1'b0 && t_rstn < 0) t_rstn = j;
            if (clk_en === 1'b0 && t_clk < 0) t_clk = j;
            if (pow === 1'b0 && t_pow < 0) t_pow = j;
            if (evt === 1'b1 && t_evt < 0) t_evt = j;
        end
        check("down rstn offset", 64'(t_rstn), 64'd1);
        check("down clk_en offset", 64'(t_clk), 64'd4);
        check("down pow offset", 64'(t_pow), 64'd5);
        check("down evt offset", 64'(t_evt), 64'd9);

        // Zero delays: fetch 4 edges after the sample edge
        pwr_dly = 8'd0; rst_dly = 8'd0; boot_addr = 64'h0000_0000_8000_0000;
        pwr_req = 1'b1;
        tick();
        wait_fetch("zero_dly", lat);
        check("zero_dly latency", 64'(lat), 64'd4);
        pwr_req = 1'b0;
        wait_off("zero_dly");
        pwr_dly = 8'd4; rst_dly = 8'd3;
        tick();

        // Request glitch during PWR_UP: still reaches RUN, then leaves at once
        boot_addr = 64'h0000_0001_2345_6788;
        pwr_req = 1'b1;
        tick(); tick();
        pwr_req = 1'b0;
        wait_fetch("glitch", lat);
        check("glitch latency", 64'(lat), 64'd8);
        tick();
        check("glitch fetch one cycle", 64'(fetch), 64'd0);
        wait_off("glitch");
        tick();

        // Reset while running: everything off on the next edge
        pwr_req = 1'b1;
        tick();
        wait_fetch("rst_run", lat);
        tick(); tick();
        rst = 1'b1;
        tick();
        check("rst_run ctrl", 64'({pow, clk_en, rstn, fetch, evt}), 64'd0);
        check("rst_run state/boot", 64'(pst) | boot_out, 64'd0);
        rst = 1'b0; pwr_req = 1'b0;
        tick(); tick();

        // Drain with the cluster never going idle
        pwr_req = 1'b1;
        tick();
        wait_fetch("long_drain", lat);
        busy = 1'b1; pwr_req = 1'b0;
        tick();
`ifdef CLUSTER_SEQ_TIMEOUT_EN
        lat = 0;
        for (int i = 0; i < 1200; i++) begin
            tick();
            lat++;
            if (pst === 2'b11) break;
        end
        check("timeout latency", 64'(lat), 64'd1025);
        check("timeout rstn", 64'(rstn), 64'd0);
        busy = 1'b0;
        wait_off("timeout");
        check("timeout sticky in off", 64'(pst), 64'(2'b11));
        pwr_req = 1'b1;
        tick(); tick();
        check("timeout cleared by power-up", 64'(pst), 64'(2'b01));
        wait_fetch("after_timeout", lat);
        check("after_timeout run", 64'(pst), 64'(2'b10));
`else
        repeat (1100) tick();
        check("no timeout pwr_state", 64'(pst), 64'(2'b01));
        check("no timeout rstn", 64'(rstn), 64'd1);
        busy = 1'b0;
        wait_off("long_drain");
`endif
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
